cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of result sources (ALU, MUL, LOAD1, LOAD2, index 0..3).
REQ-002 SHALL have parameter TAG_W, default 4, reservation-station tag width.
REQ-003 SHALL have parameter DATA_W, default 32, result data width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  N_REQ  per-source result pending.
REQ-007 SHALL have port req_tag  input  N_REQ*TAG_W  per-source producing tag, source i at bits [i*TAG_W +: TAG_W].
REQ-008 SHALL have port req_data  input  N_REQ*DATA_W  per-source result, source i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port cdb_valid  output  1  broadcast qualifier.
REQ-010 SHALL have port cdb_tag  output  TAG_W  tag being broadcast.
REQ-011 SHALL have port cdb_data  output  DATA_W  value being broadcast.
REQ-012 SHALL have port cdb_src  output  N_REQ  one-hot source of the current broadcast.
REQ-013 SHALL have port tag0_err  output  1  sticky flag, request seen with reserved tag 0.
REQ-014 SHALL have port bcast_cnt  output  16  count of broadcasts, wraps 0xFFFF->0x0000.

Function
REQ-015 SHALL follow a hold-until-seen handshake: a source holds req_valid/tag/data stable until it observes cdb_valid=1 with cdb_tag equal to its tag, then drops req_valid at the next edge.
REQ-016 SHALL register all cdb_* outputs; a winner selected at edge N is broadcast during cycle N to N+1, giving one-cycle latency from request to broadcast.
REQ-017 SHALL broadcast at most one result per cycle; cdb_src SHALL be one-hot when cdb_valid=1 and all-zero otherwise.
REQ-018 SHALL arbitrate round-robin: a pointer rr_ptr (log2 N_REQ bits) names the highest-priority source; search proceeds rr_ptr, rr_ptr+1, ... modulo N_REQ.
REQ-019 SHALL, after a grant to source k, set rr_ptr to (k+1) mod N_REQ; index N_REQ-1 wraps to 0; rr_ptr SHALL be unchanged in cycles with no grant.
REQ-020 SHALL mask out of eligibility the source named by cdb_src while cdb_valid=1, because that source's req_valid is still high for that cycle. This prevents a duplicate broadcast.
REQ-021 SHALL treat a source with req_valid=1 and tag 0 as ineligible, and SHALL set tag0_err at the next edge; tag0_err clears only on reset.
REQ-022 SHALL drive cdb_valid=0 at the next edge when no eligible source exists; cdb_tag, cdb_data and cdb_src SHALL then be all zero.
REQ-023 SHALL allow back-to-back broadcasts from different sources on consecutive cycles with no bubble.
REQ-024 SHALL allow the same source a new broadcast no earlier than two cycles after its previous one, which is the natural consequence of REQ-015 and REQ-020.
REQ-025 SHALL increment bcast_cnt by 1 at each edge where cdb_valid is loaded as 1.
REQ-026 SHALL decide by tag only; equal tags from two sources are a source error and need no special handling beyond normal arbitration.

Reset
REQ-027 SHALL, while rst_n=0 and independent of clk, force cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0, tag0_err=0 and bcast_cnt=0.
REQ-028 SHALL, on deassertion of rst_n, use the first rising edge as the first arbitration edge.
REQ-029 SHALL, when reset asserts mid-broadcast, drop the broadcast immediately and not replay it; sources re-present their requests after reset.

Verification
REQ-030 SHALL cover this single-request scenario: source 2 presents tag 5 with data 0xDEADBEEF. Required response: the next cycle shows cdb_valid=1, tag=5, data=0xDEADBEEF and src=0100. The source then drops its request, the following cycle shows cdb_valid=0, and bcast_cnt=1.
REQ-031 SHALL cover this all-request round-robin scenario: all four sources request after reset with tags 1,2,3,4. Required response: broadcast order is tags 1,2,3,4 on four consecutive cycles, with no duplicates, and rr_ptr ends at 0.
REQ-032 SHALL cover this rotation scenario: source 3 is granted, then sources 0 and 3 request again. Required response: source 0 is granted first (wrap 3->0), then source 3.
REQ-033 SHALL cover this duplicate-suppression scenario: source 1 holds req_valid high for one extra cycle after its broadcast and is the only requester. Required response: no second broadcast of its tag, and cdb_valid=0 in that cycle.
REQ-034 SHALL cover this reserved-tag scenario: source 0 requests with tag 0 while source 1 requests with tag 7. Required response: only tag 7 is broadcast, and tag0_err=1 until reset.
REQ-035 SHALL cover this counter-wrap and reset scenario: bcast_cnt is preloaded to 0xFFFF through 65535 broadcasts and one more broadcast is applied, then rst_n is pulsed low mid-cycle during a broadcast. Required response: bcast_cnt reads 0x0000 after the extra broadcast, and all outputs are 0 immediately on the reset pulse.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Common data bus interface between result sources and the CDB arbiter.
//   req_valid : per-source result pending (one bit per source)
//   req_tag   : per-source producing tag, source i at [i*TAG_W +: TAG_W]
//   req_data  : per-source result value, source i at [i*DATA_W +: DATA_W]
//   cdb_valid : broadcast qualifier
//   cdb_tag   : tag being broadcast
//   cdb_data  : value being broadcast
//   cdb_src   : one-hot source of the current broadcast
//   tag0_err  : sticky flag, a request carried reserved tag 0
//   bcast_cnt : running count of broadcasts (wraps)
// modport master : result-source side; modport slave : arbiter side.
interface cdb_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [N_REQ-1:0]        cdb_src;
    logic                    tag0_err;
    logic [15:0]             bcast_cnt;

    modport master (
        output req_valid, req_tag, req_data,
        input  cdb_valid, cdb_tag, cdb_data, cdb_src, tag0_err, bcast_cnt
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output cdb_valid, cdb_tag, cdb_data, cdb_src, tag0_err, bcast_cnt
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the common data bus. Each cycle it picks at
// most one pending result and broadcasts it, registered, in the next cycle.
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cdb_arbiter_if slave modport (requests in, broadcast out)
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  eligible;
    logic              tag0_hit;
    logic              found;
    logic [PTR_W-1:0]  sel;
    logic [PTR_W-1:0]  nxt_ptr;
    logic [TAG_W-1:0]  nxt_tag;
    logic [DATA_W-1:0] nxt_data;
    logic [N_REQ-1:0]  nxt_src;

    // The source currently on the bus still holds req_valid this cycle
    // (it drops only after seeing its tag), so it is masked to avoid a
    // duplicate broadcast. Tag 0 is reserved and never eligible.
    always_comb begin
        eligible = '0;
        tag0_hit = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.req_valid[i]) begin
                if (bus.req_tag[i*TAG_W +: TAG_W] == '0) begin
                    tag0_hit = 1'b1;
                end else if (!(bus.cdb_valid && bus.cdb_src[i])) begin
                    eligible[i] = 1'b1;
                end
            end
        end
    end

    // First eligible source searching upward from rr_ptr, modulo N_REQ.
    always_comb begin
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = PTR_W'((32'(rr_ptr) + off) % N_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        nxt_ptr  = rr_ptr;
        nxt_tag  = '0;
        nxt_data = '0;
        nxt_src  = '0;
        if (found) begin
            nxt_ptr  = (32'(sel) == 32'(N_REQ - 1)) ? '0 : sel + 1'b1;
            nxt_tag  = bus.req_tag[32'(sel)*TAG_W +: TAG_W];
            nxt_data = bus.req_data[32'(sel)*DATA_W +: DATA_W];
            nxt_src  = N_REQ'(1) << sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_data  <= '0;
            bus.cdb_src   <= '0;
            bus.tag0_err  <= 1'b0;
            bus.bcast_cnt <= '0;
        end else begin
            rr_ptr        <= nxt_ptr;
            bus.cdb_valid <= found;
            bus.cdb_tag   <= nxt_tag;
            bus.cdb_data  <= nxt_data;
            bus.cdb_src   <= nxt_src;
            bus.tag0_err  <= bus.tag0_err | tag0_hit;
            if (found) begin
                bus.bcast_cnt <= bus.bcast_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: behavioural sources following the
// hold-until-seen handshake, a per-cycle reference model of the arbitration
// rules, and directed scenarios with literal expected values.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // source state
    logic          s_valid   [N];
    logic [TW-1:0] s_tag     [N];
    logic [DW-1:0] s_data    [N];
    bit            drop_pend [N];
    bit            flood;

    // reference model state
    logic          e_valid;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_data;
    logic [N-1:0]  e_src;
    logic          e_err;
    logic [15:0]   e_cnt;
    int            e_ptr;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]             = s_valid[i];
            bus.req_tag[i*TW +: TW]      = s_tag[i];
            bus.req_data[i*DW +: DW]     = s_data[i];
        end
    endtask

    task automatic clear_sources();
        flood = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_valid[i]   = 1'b0;
            s_tag[i]     = '0;
            s_data[i]    = '0;
            drop_pend[i] = 1'b0;
        end
        drive();
    endtask

    task automatic model_reset();
        e_valid = 1'b0; e_tag = '0; e_data = '0; e_src = '0;
        e_err = 1'b0; e_cnt = '0; e_ptr = 0;
    endtask

    // Compare current outputs against the model, then advance the model
    // using the requests that the next rising edge will sample.
    task automatic model_step();
        int k;
        n_cmp++;
        if (bus.cdb_valid !== e_valid || bus.cdb_tag !== e_tag || bus.cdb_data !== e_data ||
            bus.cdb_src !== e_src || bus.tag0_err !== e_err || bus.bcast_cnt !== e_cnt ||
            32'(dut.rr_ptr) !== e_ptr) begin
            n_fail++;
            $display("FAIL model t=%0t valid %0b/%0b tag %0h/%0h data %h/%h src %b/%b err %0b/%0b cnt %0h/%0h ptr %0d/%0d",
                     $time, bus.cdb_valid, e_valid, bus.cdb_tag, e_tag, bus.cdb_data, e_data,
                     bus.cdb_src, e_src, bus.tag0_err, e_err, bus.bcast_cnt, e_cnt,
                     dut.rr_ptr, e_ptr);
        end
        k = -1;
        for (int off = 0; off < N; off++) begin
            int i;
            i = (e_ptr + off) % N;
            if (k < 0 && s_valid[i] && s_tag[i] != 0 && !(e_valid && e_src[i])) k = i;
        end
        for (int i = 0; i < N; i++)
            if (s_valid[i] && s_tag[i] == 0) e_err = 1'b1;
        if (k >= 0) begin
            e_valid = 1'b1;
            e_tag   = s_tag[k];
            e_data  = s_data[k];
            e_src   = '0;
            e_src[k] = 1'b1;
            e_ptr   = (k + 1) % N;
            e_cnt   = e_cnt + 16'd1;
        end else begin
            e_valid = 1'b0; e_tag = '0; e_data = '0; e_src = '0;
        end
    endtask

    // One clock cycle: mid-cycle check/model/observe, then source updates
    // 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_step();
        for (int i = 0; i < N; i++)
            if (s_valid[i] && bus.cdb_valid && bus.cdb_tag == s_tag[i]) drop_pend[i] = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (flood && !s_valid[i] && !drop_pend[i]) begin
                s_valid[i] = 1'b1;
                s_data[i]  = $urandom;
            end
            if (drop_pend[i]) begin
                s_valid[i]   = 1'b0;
                drop_pend[i] = 1'b0;
            end
        end
        drive();
    endtask

    // Reset pulse issued mid-cycle; outputs must clear without a clock edge.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.cdb_valid), 0);
        chk("rst_tag",   64'(bus.cdb_tag),   0);
        chk("rst_data",  64'(bus.cdb_data),  0);
        chk("rst_src",   64'(bus.cdb_src),   0);
        chk("rst_err",   64'(bus.tag0_err),  0);
        chk("rst_cnt",   64'(bus.bcast_cnt), 0);
        chk("rst_ptr",   64'(dut.rr_ptr),    0);
        clear_sources();
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic req(input int i, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        s_valid[i] = 1'b1;
        s_tag[i]   = tag;
        s_data[i]  = data;
        drive();
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        clear_sources();
        model_reset();
        #12;
        chk("init_valid", 64'(bus.cdb_valid), 0);
        chk("init_cnt",   64'(bus.bcast_cnt), 0);
        rst_n = 1'b1;
        tick();

        // single request: source 2, tag 5
        req(2, 4'd5, 32'hDEADBEEF);
        tick();
        chk("single_valid", 64'(bus.cdb_valid), 1);
        chk("single_tag",   64'(bus.cdb_tag),   5);
        chk("single_data",  64'(bus.cdb_data),  64'h0DEADBEEF);
        chk("single_src",   64'(bus.cdb_src),   4'b0100);
        tick();
        chk("single_idle",  64'(bus.cdb_valid), 0);
        chk("single_cnt",   64'(bus.bcast_cnt), 1);

        // rotation: source 3 granted, then sources 0 and 3 again
        req(3, 4'd9, 32'h9);
        tick();
        chk("rot_first_src", 64'(bus.cdb_src), 4'b1000);
        tick();
        chk("rot_gap_valid", 64'(bus.cdb_valid), 0);
        req(0, 4'hA, 32'hA0);
        req(3, 4'hB, 32'hB3);
        tick();
        chk("rot_wrap_src", 64'(bus.cdb_src), 4'b0001);
        chk("rot_wrap_tag", 64'(bus.cdb_tag), 4'hA);
        tick();
        chk("rot_next_src", 64'(bus.cdb_src), 4'b1000);
        chk("rot_next_tag", 64'(bus.cdb_tag), 4'hB);
        tick();
        chk("rot_idle", 64'(bus.cdb_valid), 0);

        // all four sources after reset, tags 1..4
        reset_pulse();
        tick();
        for (int i = 0; i < N; i++) req(i, TW'(i + 1), 32'h100 + 32'(i));
        for (int i = 0; i < N; i++) begin
            tick();
            chk("rr_tag", 64'(bus.cdb_tag), 64'(i + 1));
            chk("rr_src", 64'(bus.cdb_src), 64'(1 << i));
        end
        tick();
        chk("rr_idle", 64'(bus.cdb_valid), 0);
        chk("rr_ptr_end", 64'(dut.rr_ptr), 0);
        chk("rr_cnt", 64'(bus.bcast_cnt), 4);

        // duplicate suppression: source 1 still high in the cycle after its broadcast
        req(1, 4'd6, 32'h66);
        tick();
        chk("dup_src", 64'(bus.cdb_src), 4'b0010);
        tick();
        chk("dup_no_repeat", 64'(bus.cdb_valid), 0);
        chk("dup_cnt", 64'(bus.bcast_cnt), 5);

        // reserved tag 0 on source 0 alongside tag 7 on source 1
        req(0, 4'd0, 32'h0BAD);
        req(1, 4'd7, 32'h77);
        tick();
        chk("tag0_bcast", 64'(bus.cdb_tag), 7);
        chk("tag0_src",   64'(bus.cdb_src), 4'b0010);
        chk("tag0_err",   64'(bus.tag0_err), 1);
        tick();
        chk("tag0_idle",  64'(bus.cdb_valid), 0);
        tick();
        s_valid[0] = 1'b0;
        drive();
        tick();
        chk("tag0_sticky", 64'(bus.tag0_err), 1);

        // continuous traffic up to the counter wrap, then reset mid-broadcast
        flood = 1'b1;
        for (int i = 0; i < N; i++) req(i, TW'(i + 1), $urandom);
        guard = 0;
        while (e_cnt != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        chk("wrap_reached", 64'(guard < 70000), 1);
        chk("cnt_ffff", 64'(bus.bcast_cnt), 16'hFFFF);
        chk("err_before_rst", 64'(bus.tag0_err), 1);
        tick();
        chk("cnt_wrap", 64'(bus.bcast_cnt), 0);
        chk("wrap_valid", 64'(bus.cdb_valid), 1);
        #2;
        reset_pulse();
        tick();
        tick();
        chk("post_rst_idle", 64'(bus.cdb_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
